// File: rtl/cpu6_memstage_lsu.sv
// MEM-stage load/store unit: issues one req/ack bus access per M-stage
// memory instruction, stalls the pipeline until it completes, and formats loads.
module cpu6_memstage_lsu #(
    parameter int unsigned CPU6_XLEN         = 32,
    parameter int unsigned CPU6_LSWIDTH_SIZE = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flashM,
    input  logic [CPU6_LSWIDTH_SIZE-1:0] lswidthM,
    input  logic                         loadsignextM,
    input  logic                         memwriteM,
    input  logic                         memtoregM,
    input  logic [CPU6_XLEN-1:0]         writedataM,
    input  logic [CPU6_XLEN-1:0]         aluoutM,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [CPU6_XLEN-1:0]         mem_addr,
    output logic [3:0]                   mem_be,
    output logic [CPU6_XLEN-1:0]         mem_wdata,
    input  logic                         mem_ack,
    input  logic [CPU6_XLEN-1:0]         mem_rdata,
    output logic [CPU6_XLEN-1:0]         readdataM,
    output logic                         stallM,
    output logic                         misalignM
);

    localparam int unsigned XLEN = CPU6_XLEN;
    localparam int unsigned LSW  = CPU6_LSWIDTH_SIZE;

    localparam logic [LSW-1:0] LSW_BYTE = LSW'(0);
    localparam logic [LSW-1:0] LSW_HALF = LSW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [LSW-1:0]    width_q, width_d;
    logic              sext_q, sext_d;
    logic              abort_q, abort_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              is_byte_c;
    logic              is_half_c;
    logic              access_c;
    logic              misaligned_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [15:0]       shifted_c;
    logic [XLEN-1:0]   load_c;

    // Decode of the M-stage request: access condition, alignment, lanes.
    always_comb begin
        is_byte_c    = (lswidthM == LSW_BYTE);
        is_half_c    = (lswidthM == LSW_HALF);
        access_c     = (memwriteM | memtoregM) & ~flashM;
        misaligned_c = (is_half_c & aluoutM[0])
                     | (~is_byte_c & ~is_half_c & (aluoutM[1:0] != 2'b00));
        if (is_byte_c) begin
            be_c    = 4'b0001 << aluoutM[1:0];
            wdata_c = {(XLEN/8){writedataM[7:0]}};
        end else if (is_half_c) begin
            be_c    = 4'b0011 << {aluoutM[1], 1'b0};
            wdata_c = {(XLEN/16){writedataM[15:0]}};
        end else begin
            be_c    = 4'b1111;
            wdata_c = writedataM;
        end
    end

    // Load alignment and extension, using the attributes latched at issue.
    always_comb begin
        shifted_c = 16'(mem_rdata >> {off_q, 3'b000});
        if (width_q == LSW_BYTE) begin
            load_c = {{(XLEN-8){sext_q & shifted_c[7]}}, shifted_c[7:0]};
        end else if (width_q == LSW_HALF) begin
            load_c = {{(XLEN-16){sext_q & shifted_c[15]}}, shifted_c[15:0]};
        end else begin
            load_c = mem_rdata;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        width_d = width_q;
        sext_d  = sext_q;
        abort_d = abort_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (access_c & ~misaligned_c) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = memwriteM;
                    addr_d  = {aluoutM[XLEN-1:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    off_d   = aluoutM[1:0];
                    width_d = lswidthM;
                    sext_d  = loadsignextM;
                    abort_d = 1'b0;
                end
            end
            ST_BUSY: begin
                // A flushed access still runs to completion on the bus.
                abort_d = abort_q | flashM;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    abort_d = 1'b0;
                    if (abort_q | flashM) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        if (!we_q) begin
                            rdata_d = load_c;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            width_q <= '0;
            sext_q  <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            width_q <= width_d;
            sext_q  <= sext_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall covers the issue cycle and every BUSY cycle; misalign is a same-cycle flag.
    assign stallM    = (state_q == ST_BUSY)
                     | ((state_q == ST_IDLE) & access_c & ~misaligned_c);
    assign misalignM = (state_q == ST_IDLE) & access_c & misaligned_c;

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign readdataM = rdata_q;

endmodule

// File: tb/tb_cpu6_memstage_lsu.sv
// Self-checking bench for cpu6_memstage_lsu: scoreboarded bus transactions,
// misalignment, flush-while-busy and reset-while-busy scenarios.
module tb_cpu6_memstage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        flashM;
    logic [1:0]  lswidthM;
    logic        loadsignextM;
    logic        memwriteM;
    logic        memtoregM;
    logic [31:0] writedataM;
    logic [31:0] aluoutM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] readdataM;
    logic        stallM;
    logic        misalignM;

    always #5 clk = ~clk;

    cpu6_memstage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .flashM       (flashM),
        .lswidthM     (lswidthM),
        .loadsignextM (loadsignextM),
        .memwriteM    (memwriteM),
        .memtoregM    (memtoregM),
        .writedataM   (writedataM),
        .aluoutM      (aluoutM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .misalignM    (misalignM)
    );

    typedef struct {
        logic        wr;
        logic        rq;
        logic [1:0]  width;
        logic        sext;
        logic [31:0] wd;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_model;
    int          errors = 0;
    int          checks = 0;

    function automatic txn_t mk(input logic wr, input logic rq, input logic [1:0] w,
                                input logic s, input logic [31:0] wd, input logic [31:0] addr,
                                input logic [31:0] rdata, input int d, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rd);
        txn_t t;
        t.wr = wr; t.rq = rq; t.width = w; t.sext = s; t.wd = wd; t.addr = addr;
        t.rdata = rdata; t.delay = d; t.be = be; t.wdata = wdata; t.rd = rd;
        return t;
    endfunction

    // Byte-lane reference model used for the randomised transactions.
    function automatic txn_t model(input txn_t t);
        txn_t r;
        int   off;
        int   n;
        r   = t;
        off = int'(t.addr[1:0]);
        n   = (t.width == 2'b00) ? 1 : (t.width == 2'b01) ? 2 : 4;
        for (int i = 0; i < 4; i++) begin
            if (n == 1) begin
                r.be[i]          = (i == off);
                r.wdata[i*8 +: 8] = t.wd[7:0];
            end else if (n == 2) begin
                r.be[i]          = ((i / 2) == (off / 2));
                r.wdata[i*8 +: 8] = t.wd[(i % 2)*8 +: 8];
            end else begin
                r.be[i]          = 1'b1;
                r.wdata[i*8 +: 8] = t.wd[i*8 +: 8];
            end
        end
        r.rd = '0;
        for (int j = 0; j < n; j++) r.rd[j*8 +: 8] = t.rdata[(off + j)*8 +: 8];
        if (t.sext && n < 4)
            for (int j = n; j < 4; j++) r.rd[j*8 +: 8] = {8{r.rd[n*8 - 1]}};
        return r;
    endfunction

    task automatic idle_inputs();
        memwriteM = 1'b0; memtoregM = 1'b0; flashM = 1'b0; lswidthM = 2'b10;
        loadsignextM = 1'b0; writedataM = '0; aluoutM = '0;
    endtask

    task automatic drive_txn(input txn_t t);
        memwriteM = t.wr; memtoregM = t.rq; lswidthM = t.width;
        loadsignextM = t.sext; writedataM = t.wd; aluoutM = t.addr; flashM = 1'b0;
    endtask

    // One complete access: issue cycle, BUSY cycles up to the ack, DONE cycle.
    task automatic run_txn(input txn_t t, input string name);
        txn_t        e;
        logic [31:0] exp_rd;
        exp_q.push_back(t);
        @(posedge clk); #1;
        drive_txn(t);
        @(negedge clk);
        checks++;
        if (stallM !== 1'b1 || mem_req !== 1'b0 || misalignM !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall=%b req=%b mis=%b, required 1 0 0", name, stallM, mem_req, misalignM);
        end
        @(posedge clk); #1;
        idle_inputs();
        e = exp_q.pop_front();
        for (int k = 0; k <= e.delay; k++) begin
            if (k == e.delay) begin mem_ack = 1'b1; mem_rdata = e.rdata; end
            else mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({mem_req, stallM, mem_we, mem_addr, mem_be, mem_wdata} !==
                {1'b1, 1'b1, e.wr, {e.addr[31:2], 2'b00}, e.be, e.wdata}) begin
                errors++;
                $display("FAIL %s busy%0d: req=%b stall=%b we=%b addr=%h be=%b wdata=%h, required 1 1 %b %h %b %h",
                         name, k, mem_req, stallM, mem_we, mem_addr, mem_be, mem_wdata,
                         e.wr, {e.addr[31:2], 2'b00}, e.be, e.wdata);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        exp_rd = e.wr ? rd_model : e.rd;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stallM !== 1'b0 || readdataM !== exp_rd) begin
            errors++;
            $display("FAIL %s done: req=%b stall=%b rd=%h, required 0 0 %h", name, mem_req, stallM, readdataM, exp_rd);
        end
        rd_model = exp_rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, stallM, misalignM, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: req/stall/mis/we=%b, required 0000", {mem_req, stallM, misalignM, mem_we});
        end
        checks++;
        if ({mem_addr, mem_be, mem_wdata, readdataM} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h rd=%h, required all 0", mem_addr, mem_be, mem_wdata, readdataM);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rd_model = '0;
    endtask

    task automatic test_loads();
        run_txn(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h11223344, 32'h0000_1000, 32'hDEADBEEF, 0,
                   4'b1111, 32'h11223344, 32'hDEADBEEF), "word_load");
        run_txn(mk(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0000_2003, 32'h8000_0000, 0,
                   4'b1000, 32'h0, 32'hFFFF_FF80), "byte_load_sext");
        run_txn(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_2003, 32'h8000_0000, 1,
                   4'b1000, 32'h0, 32'h0000_0080), "byte_load_zext");
        run_txn(mk(1'b0, 1'b1, 2'b01, 1'b1, 32'h0, 32'h0000_9002, 32'h8001_1234, 2,
                   4'b1100, 32'h0, 32'hFFFF_8001), "half_load_sext");
        run_txn(mk(1'b0, 1'b1, 2'b11, 1'b1, 32'h0, 32'h0000_8000, 32'h0BAD_F00D, 0,
                   4'b1111, 32'h0, 32'h0BAD_F00D), "rsvd_width_load");
    endtask

    task automatic test_stores();
        run_txn(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0000_3002, 32'hFFFF_FFFF, 4,
                   4'b1100, 32'hABCD_ABCD, 32'h0), "half_store");
        run_txn(mk(1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_00A5, 32'h0000_7001, 32'hFFFF_FFFF, 0,
                   4'b0010, 32'hA5A5_A5A5, 32'h0), "both_set_store");
    endtask

    task automatic test_misalign();
        txn_t tab[3];
        tab[0] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_4001, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        tab[1] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h5555, 32'h0000_4003, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        tab[2] = mk(1'b0, 1'b1, 2'b11, 1'b1, 32'h0, 32'h0000_4002, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_txn(tab[i]);
            @(negedge clk);
            checks++;
            if (misalignM !== 1'b1 || stallM !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign%0d flag: mis=%b stall=%b req=%b, required 1 0 0", i, misalignM, stallM, mem_req);
            end
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            checks++;
            if (misalignM !== 1'b0 || mem_req !== 1'b0 || stallM !== 1'b0 || readdataM !== rd_model) begin
                errors++;
                $display("FAIL misalign%0d after: mis=%b req=%b stall=%b rd=%h, required 0 0 0 %h",
                         i, misalignM, mem_req, stallM, readdataM, rd_model);
            end
        end
    endtask

    task automatic test_flash_idle();
        @(posedge clk); #1;
        memtoregM = 1'b1; flashM = 1'b1; lswidthM = 2'b10; aluoutM = 32'h0000_4001;
        @(negedge clk);
        checks++;
        if (stallM !== 1'b0 || misalignM !== 1'b0) begin
            errors++;
            $display("FAIL flash_idle: stall=%b mis=%b, required 0 0", stallM, misalignM);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flash_idle_req: req=%b, required 0", mem_req);
        end
    endtask

    task automatic test_flash_busy();
        txn_t e;
        exp_q.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_5004, 32'hCAFE_F00D, 2,
                           4'b1111, 32'h0, 32'hCAFE_F00D));
        @(posedge clk); #1;
        drive_txn(exp_q[0]);
        @(negedge clk);
        @(posedge clk); #1;
        idle_inputs();
        flashM = 1'b1;
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin mem_ack = 1'b1; mem_rdata = e.rdata; end
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || stallM !== 1'b1 || mem_addr !== 32'h0000_5004) begin
                errors++;
                $display("FAIL flash_busy%0d: req=%b stall=%b addr=%h, required 1 1 00005004", k, mem_req, stallM, mem_addr);
            end
            @(posedge clk); #1;
            flashM = 1'b0;
            mem_ack = 1'b0;
        end
        // New access in the cycle after ack: only IDLE (no DONE) accepts it.
        exp_q.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_6000, 32'h1357_2468, 0,
                           4'b1111, 32'h0, 32'h1357_2468));
        drive_txn(exp_q[0]);
        @(negedge clk);
        checks++;
        if (stallM !== 1'b1 || mem_req !== 1'b0 || readdataM !== rd_model) begin
            errors++;
            $display("FAIL flash_abort: stall=%b req=%b rd=%h, required 1 0 %h", stallM, mem_req, readdataM, rd_model);
        end
        @(posedge clk); #1;
        idle_inputs();
        e = exp_q.pop_front();
        mem_ack = 1'b1; mem_rdata = e.rdata;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6000) begin
            errors++;
            $display("FAIL flash_next_busy: req=%b addr=%h, required 1 00006000", mem_req, mem_addr);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (readdataM !== e.rd || stallM !== 1'b0) begin
            errors++;
            $display("FAIL flash_next_done: rd=%h stall=%b, required %h 0", readdataM, stallM, e.rd);
        end
        rd_model = e.rd;
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        drive_txn(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_2001, 32'h0, 0, 4'b0, 32'h0, 32'h0));
        @(negedge clk);
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || stallM !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: req=%b stall=%b, required 1 1", mem_req, stallM);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        rd_model = '0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stallM !== 1'b0 || readdataM !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy: req=%b stall=%b rd=%h addr=%h, required 0 0 0 0", mem_req, stallM, readdataM, mem_addr);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (readdataM !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ack: rd=%h req=%b, required 0 0", readdataM, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        for (int i = 0; i < 12; i++) begin
            t.wr    = 1'($urandom_range(0, 1));
            t.rq    = t.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            t.width = 2'($urandom_range(0, 3));
            t.sext  = 1'($urandom_range(0, 1));
            t.wd    = $urandom;
            t.addr  = $urandom;
            if (t.width == 2'b01) t.addr[0] = 1'b0;
            if (t.width[1]) t.addr[1:0] = 2'b00;
            t.rdata = $urandom;
            t.delay = $urandom_range(0, 3);
            run_txn(model(t), "rand");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_flash_idle();
        test_flash_busy();
        test_reset_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
